// File: rtl/tx_rr2_pkg.sv
// Shared constants and helpers for the two-queue TX round-robin stage.
//   - default widths/depths
//   - queue ids and one-hot grant encodings used against the 2-way arbiter
package tx_rr2_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int DEPTH_DEF  = 4;
  localparam int CNT_W_DEF  = 16;

  localparam logic QID_0 = 1'b0;
  localparam logic QID_1 = 1'b1;

  localparam logic [1:0] GNT_Q0 = 2'b01;
  localparam logic [1:0] GNT_Q1 = 2'b10;

  // A grant is usable only if it is exactly one-hot and names a requester.
  function automatic logic grant_legal(input logic [1:0] gnt, input logic [1:0] req);
    return ((gnt == GNT_Q0) || (gnt == GNT_Q1)) && ((gnt & ~req) == 2'b00);
  endfunction

endpackage

// File: rtl/tx_desc_fifo.sv
// Synchronous descriptor FIFO, DATA_W x DEPTH (DEPTH power of 2, >= 2).
// Ports:
//   clk, rst_n     clock, async active-low reset (clears pointers/occupancy)
//   push, din      write din on the edge when push & ~full
//   pop            retire head on the edge when pop & ~empty
//   full, empty    derived from the occupancy register only
//   head           current head entry (valid when ~empty)
module tx_desc_fifo
  import tx_rr2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    occ;
  logic              do_push, do_pop;

  assign full    = (occ == (PTR_W+1)'(DEPTH));
  assign empty   = (occ == '0);
  // Full refuses a push even if a pop happens the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/tx_rr2_queue_stage.sv
// Two-queue TX descriptor buffering stage around an external 2-way RR arbiter.
// Each input stream lands in its own FIFO; non-empty queues request the
// arbiter whenever the output slot can take a descriptor, and the one-hot
// grant pops that queue into a registered valid/ready output slot.
// Ports:
//   sys_clk, sys_rst_n           clock, async active-low reset
//   in{0,1}_valid/ready/data     upstream descriptor streams (ready = ~full)
//   rr_req, rr_ena               request vector / consume strobe to arbiter
//   rr_result                    one-hot grant from arbiter (same cycle)
//   out_valid/ready/data, out_qid  output slot to next TX stage
//   grant_cnt0/1                 per-queue pop counters (TX_RR2_STATS_EN only)
// Build option: define TX_RR2_STATS_EN to add the grant counters and CNT_W.
module tx_rr2_queue_stage
  import tx_rr2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
`ifdef TX_RR2_STATS_EN
  ,
  parameter int CNT_W  = CNT_W_DEF
`endif
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  output logic [1:0]        rr_req,
  output logic              rr_ena,
  input  logic [1:0]        rr_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_qid
`ifdef TX_RR2_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  logic [1:0]              full, empty, pop;
  logic [1:0][DATA_W-1:0]  head;
  logic                    load, grant_ok;

  tx_desc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (in0_valid),
    .din   (in0_data),
    .pop   (pop[0]),
    .full  (full[0]),
    .empty (empty[0]),
    .head  (head[0])
  );

  tx_desc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (in1_valid),
    .din   (in1_data),
    .pop   (pop[1]),
    .full  (full[1]),
    .empty (empty[1]),
    .head  (head[1])
  );

  // Ready comes straight from the occupancy register, so there is no path
  // from out_ready back to the upstream interfaces.
  assign in0_ready = ~full[0];
  assign in1_ready = ~full[1];

  // Requests drop to zero under back-pressure, which also freezes the arbiter.
  assign load     = ~out_valid | out_ready;
  assign rr_req   = {load & ~empty[1], load & ~empty[0]};
  assign rr_ena   = |rr_req;
  // A malformed grant is dropped: nothing pops, the slot is not reloaded.
  assign grant_ok = rr_ena & grant_legal(rr_result, rr_req);
  assign pop      = grant_ok ? rr_result : 2'b00;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_qid   <= QID_0;
    end else if (grant_ok) begin
      out_valid <= 1'b1;
      out_data  <= rr_result[1] ? head[1] : head[0];
      out_qid   <= rr_result[1] ? QID_1 : QID_0;
    end else if (out_valid & out_ready) begin
      // Drained with nothing new loaded; out_data keeps its last value.
      // Clearing on any non-load (including a rejected grant) avoids
      // presenting an already-accepted descriptor twice.
      out_valid <= 1'b0;
    end
  end

`ifdef TX_RR2_STATS_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (pop[0]) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (pop[1]) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end
`endif

  a_grant_legal : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    rr_ena |-> grant_legal(rr_result, rr_req));

endmodule
